// File: rtl/bitonic_sort_arbiter.sv
// bitonic_sort_arbiter
// Shares one external pipelined sort engine among N_REQ requesters. Vectors are
// granted round-robin, the owner ID of each in-flight vector rides in a tag FIFO,
// and sorted results return with their ID through a FWFT response FIFO.
// Issue is credit-limited (MAX_INFLIGHT), so the response FIFO can never overflow.
// Optional: define SORT_ARB_ERR_CHECK_EN to build the sticky protocol-error flag
// (stray engine result or 2**16-cycle return timeout); otherwise err is tied 0.
module bitonic_sort_arbiter #(
    parameter  int LOG_INPUT    = 5,
    parameter  int DATA_WIDTH   = 8,
    parameter  int N_REQ        = 4,
    parameter  int MAX_INFLIGHT = 8,
    localparam int VEC_W        = DATA_WIDTH * (2 ** LOG_INPUT),
    localparam int ID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W        = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*VEC_W-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   sort_x_valid,
    output logic [VEC_W-1:0]       sort_x,
    input  logic                   sort_y_valid,
    input  logic [VEC_W-1:0]       sort_y,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [VEC_W-1:0]       rsp_data,
    output logic                   busy,
    output logic                   err
);

    localparam int AW = $clog2(MAX_INFLIGHT);
    localparam int RW = ID_W + VEC_W;

    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;
    logic             can_issue;
    logic             grant_any;
    logic [ID_W-1:0]  grant_idx;
    logic             rsp_pop;

    logic [ID_W-1:0]  tag_mem [MAX_INFLIGHT];
    logic [CNT_W-1:0] tag_wr;
    logic [CNT_W-1:0] tag_rd;
    logic             tag_empty;
    logic             ret_ok;

    logic [RW-1:0]    rsp_mem [MAX_INFLIGHT];
    logic [CNT_W-1:0] rsp_wr;
    logic [CNT_W-1:0] rsp_rd;
    logic [RW-1:0]    rsp_head;

    // Grants are suppressed while reset is asserted so req_ready reads 0 in reset.
    assign can_issue = rst && (cnt < CNT_W'(MAX_INFLIGHT));
    assign busy      = (cnt != '0);

    // Round-robin search starting at ptr; first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        if (can_issue) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (int'(ptr) + k) % N_REQ;
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = ID_W'(idx);
                end
            end
            if (grant_any) req_ready[grant_idx] = 1'b1;
        end
    end

    // Round-robin pointer moves just past the winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (grant_any)
            ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
    end

    // Issue register: granted vector goes to the engine one cycle after grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sort_x_valid <= 1'b0;
            sort_x       <= '0;
        end else begin
            sort_x_valid <= grant_any;
            if (grant_any) sort_x <= req_data[int'(grant_idx)*VEC_W +: VEC_W];
        end
    end

    // Credits: vectors issued and not yet accepted on the response port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (grant_any && !rsp_pop)
            cnt <= cnt + 1'b1;
        else if (!grant_any && rsp_pop)
            cnt <= cnt - 1'b1;
    end

    // Tag FIFO storage: owner ID written on the same edge the vector is issued.
    always_ff @(posedge clk) begin
        if (grant_any) tag_mem[tag_wr[AW-1:0]] <= grant_idx;
    end

    assign tag_empty = (tag_wr == tag_rd);
    // A result with no outstanding tag is a stray and is dropped.
    assign ret_ok    = sort_y_valid && !tag_empty;

    // Tag FIFO pointers; capacity is guaranteed by the credit limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_wr <= '0;
            tag_rd <= '0;
        end else begin
            if (grant_any) tag_wr <= tag_wr + 1'b1;
            if (ret_ok)    tag_rd <= tag_rd + 1'b1;
        end
    end

    // Response FIFO storage: sorted vector paired with the oldest tag.
    always_ff @(posedge clk) begin
        if (ret_ok) rsp_mem[rsp_wr[AW-1:0]] <= {tag_mem[tag_rd[AW-1:0]], sort_y};
    end

    assign rsp_valid = (rsp_wr != rsp_rd);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_head  = rsp_mem[rsp_rd[AW-1:0]];
    assign rsp_id    = rsp_valid ? rsp_head[VEC_W +: ID_W] : '0;
    assign rsp_data  = rsp_valid ? rsp_head[VEC_W-1:0]   : '0;

    // Response FIFO pointers; first-word-fall-through head read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_wr <= '0;
            rsp_rd <= '0;
        end else begin
            if (ret_ok)  rsp_wr <= rsp_wr + 1'b1;
            if (rsp_pop) rsp_rd <= rsp_rd + 1'b1;
        end
    end

`ifdef SORT_ARB_ERR_CHECK_EN
    logic [15:0] tmo_cnt;
    logic        err_q;

    // Sticky error: stray result, or outstanding tag with no return for 2**16 cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (!tag_empty && !sort_y_valid) tmo_cnt <= tmo_cnt + 1'b1;
            else                             tmo_cnt <= '0;
            if ((sort_y_valid && tag_empty) ||
                (!tag_empty && !sort_y_valid && (tmo_cnt == 16'hFFFF)))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bitonic_sort_arbiter.sv
// tb_bitonic_sort_arbiter
// Directed bench for bitonic_sort_arbiter with a 3-cycle stand-in sort engine.
// A transaction-level model (expected grants, credit count, response queue with
// due cycles) is compared against the DUT on every falling edge; directed
// scenarios add hand-computed literal expectations.
module tb_bitonic_sort_arbiter;

    localparam int VW  = 256;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [3:0]      req_valid = '0;
    logic [4*VW-1:0] req_data  = '0;
    logic [3:0]      req_ready;
    logic            sort_x_valid;
    logic [VW-1:0]   sort_x;
    logic            sort_y_valid;
    logic [VW-1:0]   sort_y;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [VW-1:0]   rsp_data;
    logic            busy;
    logic            err;

    logic            inj_valid = 1'b0;
    logic [VW-1:0]   inj_data  = '0;

    int errors = 0;
    int checks = 0;

    bitonic_sort_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .sort_x_valid(sort_x_valid),
        .sort_x      (sort_x),
        .sort_y_valid(sort_y_valid),
        .sort_y      (sort_y),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference sort for the model: insertion sort, ascending from element 0.
    function automatic logic [VW-1:0] isort(input logic [VW-1:0] v);
        logic [7:0]    a [32];
        logic [7:0]    t;
        logic [VW-1:0] r;
        for (int i = 0; i < 32; i++) a[i] = v[i*8 +: 8];
        for (int i = 1; i < 32; i++)
            for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        for (int i = 0; i < 32; i++) r[i*8 +: 8] = a[i];
        return r;
    endfunction

    // Stand-in engine sort: counting sort.
    function automatic logic [VW-1:0] csort(input logic [VW-1:0] v);
        int            hist [256];
        int            pos;
        logic [VW-1:0] r;
        pos = 0;
        r   = '0;
        for (int b = 0; b < 256; b++) hist[b] = 0;
        for (int i = 0; i < 32; i++) hist[v[i*8 +: 8]]++;
        for (int b = 0; b < 256; b++)
            for (int n = 0; n < hist[b]; n++) begin
                r[pos*8 +: 8] = 8'(b);
                pos++;
            end
        return r;
    endfunction

    // Stand-in engine: LAT-stage in-order pipeline sharing the reset.
    logic [LAT-1:0] ev;
    logic [VW-1:0]  ed [LAT];
    always @(posedge clk or negedge rst) begin
        if (!rst) ev <= '0;
        else      ev <= {ev[LAT-2:0], sort_x_valid};
    end
    always @(posedge clk) begin
        ed[0] <= csort(sort_x);
        for (int i = 1; i < LAT; i++) ed[i] <= ed[i-1];
    end
    assign sort_y_valid = ev[LAT-1] | inj_valid;
    assign sort_y       = inj_valid ? inj_data : ed[LAT-1];

    // Model state
    typedef struct {
        int            id;
        logic [VW-1:0] data;
        int            gcyc;
        int            rcyc;
    } exp_t;

    exp_t          q[$];
    int            m_ptr = 0;
    int            m_cnt = 0;
    logic          m_xv = 1'b0;
    logic [VW-1:0] m_xdata = '0;
    logic          m_err = 1'b0;
    int            cyc = 0;
    int            grant_log[$];
    int            rsp_log[$];
    logic [VW-1:0] rsp_dlog[$];

    // Per-cycle compare against the model, then advance the model by the
    // handshakes that the coming rising edge will commit.
    always @(negedge clk) begin : model
        logic [3:0] exp_rdy;
        int         g;
        logic       gv;
        logic       exp_rv;
        logic       tag_ne;
        logic       exp_err;
        exp_t       e;
        if (!rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_sort_x_valid", sort_x_valid, 0);
            chk("rst_sort_x", sort_x, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", err, 0);
            q.delete();
            m_ptr = 0; m_cnt = 0; m_xv = 1'b0; m_xdata = '0; m_err = 1'b0;
        end else begin
            gv = 1'b0;
            g  = 0;
            if (m_cnt < 8)
                for (int k = 0; k < 4; k++)
                    if (!gv && req_valid[(m_ptr + k) % 4]) begin
                        gv = 1'b1;
                        g  = (m_ptr + k) % 4;
                    end
            exp_rdy = gv ? 4'(1 << g) : 4'b0000;
            chk("req_ready", req_ready, exp_rdy);
            chk("sort_x_valid", sort_x_valid, m_xv);
            chk("sort_x", sort_x, m_xdata);
            chk("busy", busy, m_cnt != 0);
            exp_rv = (q.size() > 0) && (q[0].rcyc <= cyc);
            chk("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                chk("rsp_id", rsp_id, q[0].id);
                chk("rsp_data", rsp_data, q[0].data);
            end
`ifdef SORT_ARB_ERR_CHECK_EN
            exp_err = m_err;
`else
            exp_err = 1'b0;
`endif
            chk("err", err, exp_err);
            tag_ne = 1'b0;
            foreach (q[i]) if (q[i].gcyc < cyc && q[i].rcyc - 1 >= cyc) tag_ne = 1'b1;
            if (inj_valid && !tag_ne) m_err = 1'b1;
            if (exp_rv && rsp_ready) begin
                rsp_log.push_back(int'(rsp_id));
                rsp_dlog.push_back(rsp_data);
                void'(q.pop_front());
                m_cnt--;
            end
            if (gv) begin
                grant_log.push_back(g);
                e.id   = g;
                e.data = isort(req_data[g*VW +: VW]);
                e.gcyc = cyc;
                e.rcyc = cyc + LAT + 2;
                q.push_back(e);
                m_cnt++;
                m_ptr   = (g + 1) % 4;
                m_xv    = 1'b1;
                m_xdata = req_data[g*VW +: VW];
            end else begin
                m_xv = 1'b0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin : stim
        logic [VW-1:0] asc;
        int            order2 [5];
        int            order5 [3];
        order2 = '{0, 1, 2, 3, 0};
        order5 = '{0, 3, 0};
        for (int j = 0; j < 32; j++) asc[j*8 +: 8] = 8'(j);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 32; j++)
                req_data[i*VW + j*8 +: 8] = (i == 0) ? 8'(31 - j) : 8'((j*37 + i*53 + 7) % 256);

        // 1: reset with all requesters valid
        ticks(3);
        req_valid = 4'b1111;
        @(negedge clk);
        chk("t1_ready_in_reset", req_ready, 4'b0000);
        chk("t1_busy_in_reset", busy, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t1_ready_after_release", req_ready, 4'b0001);

        // 2: round-robin, five grants, free-flowing responses
        rsp_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (grant_log.size() >= 5) break;
        end
        req_valid = 4'b0000;
        ticks(15);
        chk("t2_grant_count", grant_log.size(), 5);
        chk("t2_rsp_count", rsp_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) chk("t2_grant_order", grant_log[i], order2[i]);
            if (i < rsp_log.size())   chk("t2_rsp_id_order", rsp_log[i], order2[i]);
        end
        if (rsp_dlog.size() > 0) chk("t2_rsp0_sorted", rsp_dlog[0], asc);

        // 3: back-pressure fills all credits
        grant_log.delete();
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        ticks(20);
        @(negedge clk);
        chk("t3_grants_at_limit", grant_log.size(), 8);
        chk("t3_ready_blocked", req_ready, 4'b0000);
        chk("t3_busy", busy, 1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_no_grant_during_pop", req_ready, 4'b0000);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("t3_one_more_grant", req_ready, 4'b0100);
        tick();
        @(negedge clk);
        chk("t3_blocked_again", req_ready, 4'b0000);
        chk("t3_grant_total", grant_log.size(), 9);

        // 4: pop and grant in the same cycle keep the credit count
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_full_no_grant", req_ready, 4'b0000);
        tick();
        @(negedge clk);
        chk("t4_grant_with_pop", req_ready, 4'b0100);
        chk("t4_rsp_valid_with_grant", rsp_valid, 1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        ticks(5);
        @(negedge clk);
        chk("t4_grant_total", grant_log.size(), 11);
        chk("t4_blocked_at_limit", req_ready, 4'b0000);

        // drain
        @(posedge clk); #1;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        ticks(30);
        @(negedge clk);
        chk("t4_drained_busy", busy, 0);

        // 5: sparse requests, pointer wrap
        @(posedge clk); #1;
        grant_log.delete();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b1001;
        tick();
        req_valid = 4'b0000;
        ticks(15);
        chk("t5_grant_count", grant_log.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < grant_log.size()) chk("t5_grant_order", grant_log[i], order5[i]);

        // 6: stray engine result, then mid-stream reset
        inj_data  = {8{32'hA5A5_5A5A}};
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        ticks(3);
        @(negedge clk);
        chk("t6_stray_rsp_valid", rsp_valid, 0);
`ifdef SORT_ARB_ERR_CHECK_EN
        chk("t6_stray_err", err, 1);
`else
        chk("t6_stray_err", err, 0);
`endif
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        ticks(3);
        req_valid = 4'b0000;
        ticks(3);
        @(negedge clk);
        chk("t6_busy_before_reset", busy, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_reset_busy", busy, 0);
        chk("t6_reset_rsp_valid", rsp_valid, 0);
        chk("t6_reset_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        rsp_ready = 1'b1;
        ticks(10);
        @(negedge clk);
        chk("t6_after_reset_rsp_valid", rsp_valid, 0);
        chk("t6_after_reset_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
